// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the main control pipeline and ALUControl:
// opcodes, ALUOp encodings and the packed control bundle.
package cpu_ctrl_pkg;

  localparam int OPCODE_W = 6;
  localparam int FUNCT_W  = 6;
  localparam int ALUOP_W  = 3;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_AND   = 3'b011;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b100;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 3'b101;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               reg_dst;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               reg_write;
    logic               mem_to_reg;
  } ctrl_t;

  localparam int    CTRL_W   = ALUOP_W + 7;
  localparam ctrl_t CTRL_NOP = ctrl_t'({CTRL_W{1'b0}});

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/main_control_pipe_if.sv
// ID-side request and EX/MEM/WB control bundle of the main control pipeline.
interface main_control_pipe_if #(parameter int CNT_W = 16);
  logic                                id_valid;
  logic [cpu_ctrl_pkg::OPCODE_W-1:0]   id_opcode;
  logic [cpu_ctrl_pkg::FUNCT_W-1:0]    id_funct;
  logic                                stall;
  logic                                flush;
  logic                                mem_wait;
  logic                                resume;
  logic                                ex_valid;
  logic [cpu_ctrl_pkg::ALUOP_W-1:0]    ex_alu_op;
  logic [cpu_ctrl_pkg::FUNCT_W-1:0]    ex_funct;
  logic                                ex_alu_src;
  logic                                ex_reg_dst;
  logic                                mem_read;
  logic                                mem_write;
  logic                                mem_branch;
  logic                                wb_reg_write;
  logic                                wb_mem_to_reg;
  logic                                illegal;
  logic                                halted;
  logic [CNT_W-1:0]                    retired_cnt;
  logic [CNT_W-1:0]                    bubble_cnt;

  modport master (
    output id_valid, id_opcode, id_funct, stall, flush, mem_wait, resume,
    input  ex_valid, ex_alu_op, ex_funct, ex_alu_src, ex_reg_dst,
           mem_read, mem_write, mem_branch, wb_reg_write, wb_mem_to_reg,
           illegal, halted, retired_cnt, bubble_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_funct, stall, flush, mem_wait, resume,
    output ex_valid, ex_alu_op, ex_funct, ex_alu_src, ex_reg_dst,
           mem_read, mem_write, mem_branch, wb_reg_write, wb_mem_to_reg,
           illegal, halted, retired_cnt, bubble_cnt
  );
endinterface

// File: rtl/main_control_pipe_decoder.sv
// Combinational main decoder: ID opcode -> control bundle plus illegal flag.
module main_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                illegal
);

  // Opcode lookup; anything not listed is illegal and yields an all-zero bundle.
  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.alu_op    = ALUOP_RTYPE;
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.alu_op = ALUOP_SUB;
        ctrl.branch = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_ANDI: begin
        ctrl.alu_op    = ALUOP_AND;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_ORI: begin
        ctrl.alu_op    = ALUOP_OR;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_SLTI: begin
        ctrl.alu_op    = ALUOP_SLT;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_J:    ctrl    = CTRL_NOP;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/main_control_pipe.sv
// Main control pipeline: decodes ID, carries controls through ID/EX, EX/MEM, MEM/WB,
// with stall/flush bubbles, cache-miss freeze, illegal-opcode halt and saturating counters.
module main_control_pipe
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  main_control_pipe_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_t               dec_ctrl_s;
  logic                dec_illegal_s;
  logic                load_s;
  logic                count_bubble_s;
  logic                take_illegal_s;
  state_t              next_state_s;

  state_t              state_r;
  logic                ex_valid_r;
  ctrl_t               ex_ctrl_r;
  logic [FUNCT_W-1:0]  ex_funct_r;
  logic                mem_valid_r;
  logic                mem_read_r;
  logic                mem_write_r;
  logic                mem_branch_r;
  logic                mem_reg_write_r;
  logic                mem_to_reg_r;
  logic                wb_valid_r;
  logic                wb_reg_write_r;
  logic                wb_mem_to_reg_r;
  logic                illegal_r;
  logic [CNT_W-1:0]    retired_r;
  logic [CNT_W-1:0]    bubble_r;

  main_decoder u_dec (
    .opcode  (bus.id_opcode),
    .ctrl    (dec_ctrl_s),
    .illegal (dec_illegal_s)
  );

  // Decide what EX loads this edge and where the FSM goes; flush/stall outrank illegal.
  always_comb begin
    load_s         = 1'b0;
    count_bubble_s = 1'b0;
    take_illegal_s = 1'b0;
    next_state_s   = state_r;
    case (state_r)
      ST_RUN: begin
        if (bus.flush || bus.stall) begin
          count_bubble_s = 1'b1;
        end else if (bus.id_valid && !dec_illegal_s) begin
          load_s = 1'b1;
        end else if (bus.id_valid) begin
          count_bubble_s = 1'b1;
          take_illegal_s = 1'b1;
          next_state_s   = HALT_ON_ILLEGAL ? ST_HALT : ST_RUN;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_HALT: begin
        if (bus.resume) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_HALT;
        end
      end
      default: next_state_s = ST_RUN;
    endcase
  end

  // Pipeline registers, FSM and counters; mem_wait freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= ST_RUN;
      ex_valid_r      <= 1'b0;
      ex_ctrl_r       <= CTRL_NOP;
      ex_funct_r      <= 6'd0;
      mem_valid_r     <= 1'b0;
      mem_read_r      <= 1'b0;
      mem_write_r     <= 1'b0;
      mem_branch_r    <= 1'b0;
      mem_reg_write_r <= 1'b0;
      mem_to_reg_r    <= 1'b0;
      wb_valid_r      <= 1'b0;
      wb_reg_write_r  <= 1'b0;
      wb_mem_to_reg_r <= 1'b0;
      illegal_r       <= 1'b0;
      retired_r       <= {CNT_W{1'b0}};
      bubble_r        <= {CNT_W{1'b0}};
    end else if (!bus.mem_wait) begin
      state_r         <= next_state_s;
      ex_valid_r      <= load_s;
      ex_ctrl_r       <= load_s ? dec_ctrl_s : CTRL_NOP;
      ex_funct_r      <= load_s ? bus.id_funct : 6'd0;
      mem_valid_r     <= ex_valid_r;
      mem_read_r      <= ex_valid_r & ex_ctrl_r.mem_read;
      mem_write_r     <= ex_valid_r & ex_ctrl_r.mem_write;
      mem_branch_r    <= ex_valid_r & ex_ctrl_r.branch;
      mem_reg_write_r <= ex_valid_r & ex_ctrl_r.reg_write;
      mem_to_reg_r    <= ex_valid_r & ex_ctrl_r.mem_to_reg;
      wb_valid_r      <= mem_valid_r;
      wb_reg_write_r  <= mem_valid_r & mem_reg_write_r;
      wb_mem_to_reg_r <= mem_valid_r & mem_to_reg_r;
      illegal_r       <= take_illegal_s;
      if (wb_valid_r && retired_r != CNT_MAX) begin
        retired_r <= retired_r + CNT_ONE;
      end
      if (count_bubble_s && bubble_r != CNT_MAX) begin
        bubble_r <= bubble_r + CNT_ONE;
      end
    end
  end

  assign bus.ex_valid      = ex_valid_r;
  assign bus.ex_alu_op     = ex_ctrl_r.alu_op;
  assign bus.ex_funct      = ex_funct_r;
  assign bus.ex_alu_src    = ex_ctrl_r.alu_src;
  assign bus.ex_reg_dst    = ex_ctrl_r.reg_dst;
  assign bus.mem_read      = mem_read_r;
  assign bus.mem_write     = mem_write_r;
  assign bus.mem_branch    = mem_branch_r;
  assign bus.wb_reg_write  = wb_reg_write_r;
  assign bus.wb_mem_to_reg = wb_mem_to_reg_r;
  assign bus.illegal       = illegal_r;
  assign bus.halted        = (state_r == ST_HALT);
  assign bus.retired_cnt   = retired_r;
  assign bus.bubble_cnt    = bubble_r;

endmodule

// File: tb/tb_main_control_pipe.sv
// Directed bench for main_control_pipe (CNT_W=4): reset, stream, stall/flush,
// cache-miss freeze, illegal halt/resume and counter saturation.
module tb_main_control_pipe;
  import cpu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  main_control_pipe_if #(.CNT_W(4)) bus ();

  main_control_pipe #(.CNT_W(4), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn);
    bus.id_valid  = v;
    bus.id_opcode = op;
    bus.id_funct  = fn;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 6'd0, 6'd0);
    bus.stall = 1'b0; bus.flush = 1'b0; bus.mem_wait = 1'b0; bus.resume = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] op_bad;
    op_bad = 6'b111111;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.mem_wait = 1'b0; bus.resume = 1'b0;

    // 1 reset with a valid lw presented
    rst_n = 1'b0;
    drive(1'b1, OP_LW, 6'd0);
    tick(); tick();
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_ex_alu_op", bus.ex_alu_op, 3'b000);
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_wb_reg_write", bus.wb_reg_write, 1'b0);
    chk("rst_halted", bus.halted, 1'b0);
    chk("rst_illegal", bus.illegal, 1'b0);
    chk("rst_retired", bus.retired_cnt, 4'd0);
    chk("rst_bubble", bus.bubble_cnt, 4'd0);

    // 2 stream R, lw, sw, beq
    rst_n = 1'b1;
    drive(1'b1, OP_RTYPE, 6'b100000); tick();
    chk("s2_r_valid", bus.ex_valid, 1'b1);
    chk("s2_r_aluop", bus.ex_alu_op, 3'b000);
    chk("s2_r_funct", bus.ex_funct, 6'b100000);
    chk("s2_r_regdst", bus.ex_reg_dst, 1'b1);
    drive(1'b1, OP_LW, 6'd0); tick();
    chk("s2_lw_aluop", bus.ex_alu_op, 3'b001);
    chk("s2_lw_alusrc", bus.ex_alu_src, 1'b1);
    chk("s2_r_mem_read", bus.mem_read, 1'b0);
    drive(1'b1, OP_SW, 6'd0); tick();
    chk("s2_sw_aluop", bus.ex_alu_op, 3'b001);
    chk("s2_lw_mem_read", bus.mem_read, 1'b1);
    chk("s2_r_wb_write", bus.wb_reg_write, 1'b1);
    drive(1'b1, OP_BEQ, 6'd0); tick();
    chk("s2_beq_aluop", bus.ex_alu_op, 3'b010);
    chk("s2_sw_mem_write", bus.mem_write, 1'b1);
    chk("s2_sw_mem_read", bus.mem_read, 1'b0);
    chk("s2_lw_wb_write", bus.wb_reg_write, 1'b1);
    chk("s2_lw_wb_m2r", bus.wb_mem_to_reg, 1'b1);
    drive(1'b0, 6'd0, 6'd0); tick();
    chk("s2_idle_valid", bus.ex_valid, 1'b0);
    chk("s2_beq_branch", bus.mem_branch, 1'b1);
    chk("s2_sw_wb_write", bus.wb_reg_write, 1'b0);
    chk("s2_retired_mid", bus.retired_cnt, 4'd2);
    tick();
    chk("s2_beq_wb_write", bus.wb_reg_write, 1'b0);
    tick();
    chk("s2_retired", bus.retired_cnt, 4'd4);
    chk("s2_bubble", bus.bubble_cnt, 4'd0);

    // 3 stall on lw, then flush on beq
    do_reset();
    drive(1'b1, OP_RTYPE, 6'b100010); tick();
    bus.stall = 1'b1; drive(1'b1, OP_LW, 6'd0); tick();
    chk("s3_stall_valid", bus.ex_valid, 1'b0);
    chk("s3_stall_bubble", bus.bubble_cnt, 4'd1);
    bus.stall = 1'b0; tick();
    chk("s3_lw_valid", bus.ex_valid, 1'b1);
    chk("s3_lw_aluop", bus.ex_alu_op, 3'b001);
    chk("s3_r_wb_write", bus.wb_reg_write, 1'b1);
    bus.flush = 1'b1; drive(1'b1, OP_BEQ, 6'd0); tick();
    chk("s3_flush_valid", bus.ex_valid, 1'b0);
    chk("s3_lw_mem_read", bus.mem_read, 1'b1);
    chk("s3_flush_bubble", bus.bubble_cnt, 4'd2);
    bus.flush = 1'b0; drive(1'b0, 6'd0, 6'd0); tick();
    chk("s3_no_branch1", bus.mem_branch, 1'b0);
    chk("s3_lw_wb_write", bus.wb_reg_write, 1'b1);
    tick();
    chk("s3_no_branch2", bus.mem_branch, 1'b0);
    chk("s3_retired", bus.retired_cnt, 4'd2);
    chk("s3_bubble_end", bus.bubble_cnt, 4'd2);

    // 4 mem_wait freeze with flush pending
    do_reset();
    drive(1'b1, OP_ADDI, 6'd0); tick();
    drive(1'b1, OP_ORI, 6'd0); tick();
    drive(1'b1, OP_ANDI, 6'd0); tick();
    chk("s4_andi_aluop", bus.ex_alu_op, 3'b011);
    chk("s4_addi_wb", bus.wb_reg_write, 1'b1);
    bus.mem_wait = 1'b1; bus.flush = 1'b1; drive(1'b1, OP_SLTI, 6'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s4_frz_valid", bus.ex_valid, 1'b1);
      chk("s4_frz_aluop", bus.ex_alu_op, 3'b011);
      chk("s4_frz_wb", bus.wb_reg_write, 1'b1);
      chk("s4_frz_retired", bus.retired_cnt, 4'd0);
      chk("s4_frz_bubble", bus.bubble_cnt, 4'd0);
    end
    bus.mem_wait = 1'b0; tick();
    chk("s4_flush_valid", bus.ex_valid, 1'b0);
    chk("s4_flush_bubble", bus.bubble_cnt, 4'd1);
    chk("s4_retired", bus.retired_cnt, 4'd1);
    bus.flush = 1'b0; drive(1'b0, 6'd0, 6'd0);

    // 5 flushed illegal is harmless; real illegal halts until resume
    do_reset();
    bus.flush = 1'b1; drive(1'b1, op_bad, 6'd0); tick();
    chk("s5_fl_illegal", bus.illegal, 1'b0);
    chk("s5_fl_halted", bus.halted, 1'b0);
    chk("s5_fl_bubble", bus.bubble_cnt, 4'd1);
    bus.flush = 1'b0; tick();
    chk("s5_illegal", bus.illegal, 1'b1);
    chk("s5_halted", bus.halted, 1'b1);
    chk("s5_ill_valid", bus.ex_valid, 1'b0);
    chk("s5_ill_bubble", bus.bubble_cnt, 4'd2);
    drive(1'b1, OP_ADDI, 6'd0); tick();
    chk("s5_pulse_end", bus.illegal, 1'b0);
    chk("s5_still_halted", bus.halted, 1'b1);
    chk("s5_ignored", bus.ex_valid, 1'b0);
    tick();
    chk("s5_ignored2", bus.ex_valid, 1'b0);
    chk("s5_halt_bubble", bus.bubble_cnt, 4'd2);
    bus.resume = 1'b1; tick();
    chk("s5_resumed", bus.halted, 1'b0);
    chk("s5_resume_edge", bus.ex_valid, 1'b0);
    bus.resume = 1'b0; tick();
    chk("s5_addi_valid", bus.ex_valid, 1'b1);
    chk("s5_addi_aluop", bus.ex_alu_op, 3'b001);
    chk("s5_addi_alusrc", bus.ex_alu_src, 1'b1);

    // 6 retired counter saturation
    do_reset();
    drive(1'b1, OP_ADDI, 6'd0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) chk("s6_retired_10", bus.retired_cnt, 4'd7);
    end
    drive(1'b0, 6'd0, 6'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("s6_retired_sat", bus.retired_cnt, 4'd15);
    chk("s6_bubble", bus.bubble_cnt, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
